coin_acceptor: RTL and testbench

Front-end stage that converts the two raw coin-slot sensors (5 rs, 10 rs) into clean, one-cycle coin codes for the vending-machine FSM, which decodes in = 01 as 5 rs and 10 as 10 rs. The stage synchronises and debounces each sensor, detects coin insertions, and rejects simultaneous or overflow coins. Accepted coins are buffered in a small FIFO and released one per cycle while the consumer asserts ready. Its coin/coin_valid outputs drive the FSM's in port directly.

---
 rtl/vm_pkg.sv | 15 +
 rtl/coin_debounce.sv | 55 +++++
 rtl/coin_acceptor.sv | 94 +++++++++
 tb/tb_coin_acceptor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Coin codes shared by the coin front end and the vending-machine FSM.
// The FSM decodes in = 01 as 5 rs and in = 10 as 10 rs.
package vm_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_5    = 2'b01;
    localparam coin_t COIN_10   = 2'b10;

    function automatic coin_t coin_of(input logic is_ten);
        return is_ten ? COIN_10 : COIN_5;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor: 2-flop synchroniser, counting debouncer and an armed
// rising-edge detector producing a one-cycle registered coin event.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          armed;
    logic [1:0]    primed;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (sync2 != level) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            armed  <= 1'b0;
            primed <= 2'b00;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Arm only once sync2 carries a post-reset sample of the sensor,
            // so a sensor held high across reset never looks like a new coin.
            if (primed[1] && !level && !sync2) begin
                armed <= 1'b1;
            end
            rise <= flip && !level && armed;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounced 5/10 rs sensors, reject of simultaneous or
// overflow coins, and a small FIFO releasing one coin code per cycle.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin5_raw,
    input  logic                         coin10_raw,
    input  logic                         ready,
    output logic [1:0]                   coin,
    output logic                         coin_valid,
    output logic                         reject,
    output logic                         fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]  coin_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic                  ev5;
    logic                  ev10;
    logic                  both;
    logic                  single;
    logic                  is_full;
    logic                  push;
    logic                  pop;
    logic                  refuse;
    logic [FIFO_DEPTH-1:0] slots;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db5 (
        .clk  (clk),
        .rst  (rst),
        .raw  (coin5_raw),
        .rise (ev5)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db10 (
        .clk  (clk),
        .rst  (rst),
        .raw  (coin10_raw),
        .rise (ev10)
    );

    // Fullness uses the pre-dequeue count: a same-cycle pop frees no room.
    assign both    = ev5 && ev10;
    assign single  = ev5 ^ ev10;
    assign is_full = (count == FULL);
    assign push    = single && !is_full;
    assign refuse  = both || (single && is_full);
    assign pop     = ready && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            coin       <= COIN_NONE;
            coin_valid <= 1'b0;
            reject     <= 1'b0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= ev10;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            coin       <= pop ? coin_of(slots[rd_ptr]) : COIN_NONE;
            coin_valid <= pop;
            reject     <= refuse;
        end
    end

    assign fifo_full  = is_full;
    assign coin_count = count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus queues expected coin codes,
// a negedge monitor pops and compares every presented coin.
module tb_coin_acceptor;
    import vm_pkg::*;

    localparam int DB    = 4;
    localparam int DEPTH = 4;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       coin5_raw  = 1'b0;
    logic       coin10_raw = 1'b0;
    logic       ready      = 1'b0;
    logic [1:0] coin;
    logic       coin_valid;
    logic       reject;
    logic       fifo_full;
    logic [2:0] coin_count;

    int    n_tests   = 0;
    int    n_fail    = 0;
    int    cyc       = 0;
    int    rej_seen  = 0;
    int    valid_cyc = -1;
    int    run       = 0;
    int    best_run  = 0;
    coin_t exp_q[$];
    coin_t mon_exp;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .ready      (ready),
        .coin       (coin),
        .coin_valid (coin_valid),
        .reject     (reject),
        .fifo_full  (fifo_full),
        .coin_count (coin_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reject) rej_seen++;
        if (coin_valid) begin
            run++;
            if (run > best_run) best_run = run;
            valid_cyc = cyc;
        end else begin
            run = 0;
        end
        if (coin_valid || coin != COIN_NONE) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_coin: got coin=%b valid=%b, required no coin",
                         coin, coin_valid);
            end else begin
                mon_exp = exp_q.pop_front();
                if (coin !== mon_exp || coin_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL coin_out: got coin=%b valid=%b, required coin=%b valid=1",
                             coin, coin_valid, mon_exp);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            step(1);
            k++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic insert(input logic ten, input int hi, input int lo);
        if (ten) coin10_raw = 1'b1;
        else     coin5_raw  = 1'b1;
        step(hi);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        step(lo);
    endtask

    initial begin
        int e;
        int r0;

        step(3);
        check("rst_coin", int'(coin), 0);
        check("rst_valid", int'(coin_valid), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_full", int'(fifo_full), 0);
        check("rst_count", int'(coin_count), 0);
        rst = 1'b0;
        step(10);

        // single 5 rs coin, latency from first sampled edge
        ready = 1'b1;
        r0 = rej_seen;
        e = cyc + 1;
        exp_q.push_back(COIN_5);
        coin5_raw = 1'b1;
        step(20);
        coin5_raw = 1'b0;
        wait_drain("c5");
        step(10);
        check("c5_latency", valid_cyc - e, 3 + DB);
        check("c5_no_reject", rej_seen - r0, 0);

        // short pulses filtered, then a real 10 rs coin
        r0 = rej_seen;
        repeat (8) begin
            coin10_raw = 1'b1;
            step(2);
            coin10_raw = 1'b0;
            step(2);
        end
        check("glitch_count", int'(coin_count), 0);
        exp_q.push_back(COIN_10);
        insert(1'b1, 10, 0);
        wait_drain("c10");
        step(10);
        check("glitch_no_reject", rej_seen - r0, 0);

        // both sensors together
        r0 = rej_seen;
        coin5_raw  = 1'b1;
        coin10_raw = 1'b1;
        step(12);
        check("both_count", int'(coin_count), 0);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        step(12);
        check("both_reject", rej_seen - r0, 1);

        // fill, overflow, drain back-to-back
        ready = 1'b0;
        r0 = rej_seen;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(COIN_5);
            insert(1'b0, 8, 8);
        end
        check("fill_full", int'(fifo_full), 1);
        check("fill_count", int'(coin_count), 4);
        check("fill_no_reject", rej_seen - r0, 0);
        insert(1'b0, 8, 8);
        check("ovf_reject", rej_seen - r0, 1);
        check("ovf_count", int'(coin_count), 4);
        best_run = 0;
        ready = 1'b1;
        wait_drain("ovf");
        step(3);
        check("drain_run", best_run, 4);
        check("drain_count", int'(coin_count), 0);
        check("drain_full", int'(fifo_full), 0);

        // ordering 5,10,10,5
        ready = 1'b0;
        exp_q.push_back(COIN_5);
        insert(1'b0, 8, 8);
        exp_q.push_back(COIN_10);
        insert(1'b1, 8, 8);
        exp_q.push_back(COIN_10);
        insert(1'b1, 8, 8);
        exp_q.push_back(COIN_5);
        insert(1'b0, 8, 8);
        check("order_count", int'(coin_count), 4);
        ready = 1'b1;
        wait_drain("order");
        step(3);

        // sensor held high across reset
        coin5_raw = 1'b1;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(20);
        check("held_count", int'(coin_count), 0);
        coin5_raw = 1'b0;
        step(10);
        exp_q.push_back(COIN_5);
        insert(1'b0, 10, 0);
        wait_drain("rearm");
        step(10);

        // reset discards buffered coins
        ready = 1'b0;
        r0 = rej_seen;
        repeat (3) insert(1'b0, 8, 8);
        check("buf3_count", int'(coin_count), 3);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        check("flush_count", int'(coin_count), 0);
        check("flush_full", int'(fifo_full), 0);
        ready = 1'b1;
        step(15);
        check("flush_valid", int'(coin_valid), 0);
        check("flush_no_reject", rej_seen - r0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
